// File: rtl/riscv_next_pc_ctrl_if.sv
// Fetch/decode/redirect bundle of the next-PC sequencer, together with the
// per-instruction control-flow summary that decode hands to it.
interface riscv_next_pc_ctrl_if #(
  parameter int ADDR_WIDTH = 64,
  parameter int RAS_DEPTH  = 8
);

  localparam int CNT_W = $clog2(RAS_DEPTH + 1);

  // imm is already sign-extended to ADDR_WIDTH; imm_sign is its sign bit.
  typedef struct packed {
    logic                  jal;
    logic                  jalr;
    logic                  branch;
    logic                  rs1_zero;
    logic                  rs1_ra;
    logic [ADDR_WIDTH-1:0] imm;
    logic                  imm_sign;
  } next_instr_signals_t;

  // Fetch handshake: a request is transferred in every cycle where
  // o_fetch_valid && i_fetch_ready.  While valid is high and not accepted,
  // o_fetch_pc is stable unless o_flush rises, which abandons the request.
  logic [ADDR_WIDTH-1:0] o_fetch_pc;
  logic                  o_fetch_valid;
  logic                  i_fetch_ready;

  logic                  i_dec_valid;
  logic [ADDR_WIDTH-1:0] i_dec_pc;
  next_instr_signals_t   i_signals;
  logic                  i_rd_link;

  logic                  i_redirect;
  logic [ADDR_WIDTH-1:0] i_redirect_pc;

  logic                  o_flush;
  logic [CNT_W-1:0]      o_ras_count;

  modport master (
    output o_fetch_pc, o_fetch_valid, o_flush, o_ras_count,
    input  i_fetch_ready, i_dec_valid, i_dec_pc, i_signals, i_rd_link,
           i_redirect, i_redirect_pc
  );

  modport slave (
    input  o_fetch_pc, o_fetch_valid, o_flush, o_ras_count,
    output i_fetch_ready, i_dec_valid, i_dec_pc, i_signals, i_rd_link,
           i_redirect, i_redirect_pc
  );

endinterface

// File: rtl/riscv_next_pc_ctrl.sv
// Next-PC sequencer: owns the fetch PC, statically predicts jal / backward
// branches / returns via a circular RAS, and stalls on unpredictable jalr.
module riscv_next_pc_ctrl #(
  parameter int                    ADDR_WIDTH = 64,
  parameter int                    RAS_DEPTH  = 8,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  riscv_next_pc_ctrl_if.master bus,
  output logic                 o_dbg_wait_jalr
);

  localparam int CNT_W = $clog2(RAS_DEPTH + 1);
  localparam int PTR_W = $clog2(RAS_DEPTH);

  typedef enum logic {
    ST_RUN       = 1'b0,
    ST_WAIT_JALR = 1'b1
  } state_e;

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] pc_q;
  logic                  valid_q;
  logic                  flush_q;
  logic [CNT_W-1:0]      count_q;
  logic [PTR_W-1:0]      ptr_q;
  logic [ADDR_WIDTH-1:0] ras_q [RAS_DEPTH];

  logic                  dec_en;
  logic                  pred_taken;
  logic                  go_wait;
  logic                  ras_push;
  logic                  ras_pop;
  logic                  ras_replace;
  logic [ADDR_WIDTH-1:0] pred_target;
  logic [ADDR_WIDTH-1:0] link;
  logic [ADDR_WIDTH-1:0] ras_top;
  logic [ADDR_WIDTH-1:0] ret_sum;
  logic [PTR_W-1:0]      ptr_inc;
  logic [PTR_W-1:0]      ptr_dec;
  logic [CNT_W-1:0]      count_inc;

  assign link      = bus.i_dec_pc + ADDR_WIDTH'(4);
  assign ras_top   = ras_q[ptr_q];
  assign ret_sum   = ras_top + bus.i_signals.imm;
  assign ptr_inc   = ptr_q + PTR_W'(1);
  assign ptr_dec   = ptr_q - PTR_W'(1);
  assign count_inc = (count_q == CNT_W'(RAS_DEPTH)) ? count_q : count_q + CNT_W'(1);

  // A decoded instruction seen while flush is high is wrong-path; a redirect
  // in the same cycle also wins over it, so no RAS update can leak through.
  assign dec_en = bus.i_dec_valid && !flush_q && (state_q == ST_RUN) && !bus.i_redirect;

  always_comb begin
    pred_taken  = 1'b0;
    go_wait     = 1'b0;
    ras_push    = 1'b0;
    ras_pop     = 1'b0;
    ras_replace = 1'b0;
    pred_target = '0;
    if (dec_en) begin
      if (bus.i_signals.jal) begin
        pred_taken  = 1'b1;
        pred_target = bus.i_dec_pc + bus.i_signals.imm;
        ras_push    = bus.i_rd_link;
      end else if (bus.i_signals.jalr) begin
        if (bus.i_signals.rs1_zero) begin
          pred_taken  = 1'b1;
          pred_target = {bus.i_signals.imm[ADDR_WIDTH-1:1], 1'b0};
          ras_push    = bus.i_rd_link;
        end else if (bus.i_signals.rs1_ra && (count_q != '0)) begin
          // Return that also links (e.g. coroutine swap): pop+push collapses
          // into overwriting the top entry.
          pred_taken  = 1'b1;
          pred_target = {ret_sum[ADDR_WIDTH-1:1], 1'b0};
          ras_replace = bus.i_rd_link;
          ras_pop     = !bus.i_rd_link;
        end else begin
          go_wait = 1'b1;
        end
      end else if (bus.i_signals.branch && bus.i_signals.imm_sign) begin
        pred_taken  = 1'b1;
        pred_target = bus.i_dec_pc + bus.i_signals.imm;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_RUN;
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
      flush_q <= 1'b0;
      count_q <= '0;
      ptr_q   <= '0;
      for (int i = 0; i < RAS_DEPTH; i++) begin
        ras_q[i] <= '0;
      end
    end else begin
      flush_q <= 1'b0;
      if (bus.i_redirect) begin
        state_q <= ST_RUN;
        pc_q    <= bus.i_redirect_pc;
        valid_q <= 1'b1;
        flush_q <= 1'b1;
      end else if (state_q == ST_WAIT_JALR) begin
        valid_q <= 1'b0;
      end else begin
        valid_q <= 1'b1;
        if (pred_taken) begin
          pc_q    <= pred_target;
          flush_q <= 1'b1;
        end else if (go_wait) begin
          state_q <= ST_WAIT_JALR;
          valid_q <= 1'b0;
          flush_q <= 1'b1;
        end else if (valid_q && bus.i_fetch_ready) begin
          pc_q <= pc_q + ADDR_WIDTH'(4);
        end
        // A push onto a full stack lands on the oldest slot; count saturates.
        if (ras_replace) begin
          ras_q[ptr_q] <= link;
        end else if (ras_push) begin
          ptr_q          <= ptr_inc;
          ras_q[ptr_inc] <= link;
          count_q        <= count_inc;
        end else if (ras_pop) begin
          ptr_q   <= ptr_dec;
          count_q <= count_q - CNT_W'(1);
        end
      end
    end
  end

  assign bus.o_fetch_pc    = pc_q;
  assign bus.o_fetch_valid = valid_q;
  assign bus.o_flush       = flush_q;
  assign bus.o_ras_count   = count_q;
  assign o_dbg_wait_jalr   = (state_q == ST_WAIT_JALR);

endmodule

// File: tb/tb_riscv_next_pc_ctrl.sv
// Directed bench for riscv_next_pc_ctrl: the driver queues the expected
// fetch-side outputs per cycle, a negedge monitor pops and compares them.
module tb_riscv_next_pc_ctrl;

  localparam int            AW     = 64;
  localparam int            RD     = 8;
  localparam int            CW     = $clog2(RD + 1);
  localparam int            EW     = AW + CW + 2;
  localparam logic [AW-1:0] RST_PC = 64'h1000;
  localparam logic [AW-1:0] NEG8   = 64'hFFFF_FFFF_FFFF_FFF8;

  logic clk;
  logic rst_n;
  logic dbg_wait;

  riscv_next_pc_ctrl_if #(.ADDR_WIDTH(AW), .RAS_DEPTH(RD)) bus ();

  riscv_next_pc_ctrl #(
    .ADDR_WIDTH(AW),
    .RAS_DEPTH (RD),
    .RESET_PC  (RST_PC)
  ) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .bus            (bus),
    .o_dbg_wait_jalr(dbg_wait)
  );

  logic [EW-1:0] exp_q[$];
  string         tag_q[$];
  int            n_checks = 0;
  int            n_fails  = 0;
  logic [EW-1:0] mon_act;
  logic [EW-1:0] mon_exp;
  string         mon_tag;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // monitor: every cycle the DUT presents a request or a flush is checked
  always @(negedge clk) begin
    if (rst_n === 1'b1 && (bus.o_fetch_valid === 1'b1 || bus.o_flush === 1'b1)) begin
      mon_act = {bus.o_flush, bus.o_fetch_valid, bus.o_ras_count, bus.o_fetch_pc};
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fails++;
        $display("FAIL out_unexpected: got flush=%0b valid=%0b cnt=%0d pc=%h, need no output",
                 mon_act[EW-1], mon_act[EW-2], mon_act[AW+CW-1:AW], mon_act[AW-1:0]);
      end else begin
        mon_exp = exp_q.pop_front();
        mon_tag = tag_q.pop_front();
        if (mon_act !== mon_exp) begin
          n_fails++;
          $display("FAIL %s: got flush=%0b valid=%0b cnt=%0d pc=%h, need flush=%0b valid=%0b cnt=%0d pc=%h",
                   mon_tag, mon_act[EW-1], mon_act[EW-2], mon_act[AW+CW-1:AW], mon_act[AW-1:0],
                   mon_exp[EW-1], mon_exp[EW-2], mon_exp[AW+CW-1:AW], mon_exp[AW-1:0]);
        end
      end
    end
  end

  // driver tasks
  task automatic expect_out(input string tag, input logic f, input logic v,
                            input int cnt, input logic [AW-1:0] pc);
    exp_q.push_back({f, v, CW'(cnt), pc});
    tag_q.push_back(tag);
  endtask

  task automatic check(input string tag, input logic [AW-1:0] act, input logic [AW-1:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fails++;
      $display("FAIL %s: got %h, need %h", tag, act, exp_v);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.i_dec_valid   = 1'b0;
    bus.i_dec_pc      = '0;
    bus.i_signals     = '0;
    bus.i_rd_link     = 1'b0;
    bus.i_redirect    = 1'b0;
    bus.i_redirect_pc = '0;
  endtask

  task automatic drive_jal(input logic [AW-1:0] pc, input logic [AW-1:0] imm, input logic lnk);
    idle();
    bus.i_dec_valid        = 1'b1;
    bus.i_dec_pc           = pc;
    bus.i_signals.jal      = 1'b1;
    bus.i_signals.imm      = imm;
    bus.i_signals.imm_sign = imm[AW-1];
    bus.i_rd_link          = lnk;
  endtask

  task automatic drive_jalr(input logic [AW-1:0] pc, input logic [AW-1:0] imm,
                            input logic zero, input logic ra, input logic lnk);
    idle();
    bus.i_dec_valid        = 1'b1;
    bus.i_dec_pc           = pc;
    bus.i_signals.jalr     = 1'b1;
    bus.i_signals.rs1_zero = zero;
    bus.i_signals.rs1_ra   = ra;
    bus.i_signals.imm      = imm;
    bus.i_signals.imm_sign = imm[AW-1];
    bus.i_rd_link          = lnk;
  endtask

  task automatic drive_branch(input logic [AW-1:0] pc, input logic [AW-1:0] imm);
    idle();
    bus.i_dec_valid        = 1'b1;
    bus.i_dec_pc           = pc;
    bus.i_signals.branch   = 1'b1;
    bus.i_signals.imm      = imm;
    bus.i_signals.imm_sign = imm[AW-1];
  endtask

  task automatic drive_redirect(input logic [AW-1:0] pc);
    bus.i_redirect    = 1'b1;
    bus.i_redirect_pc = pc;
  endtask

  // stimulus
  initial begin
    logic [AW-1:0] dp;
    logic [AW-1:0] ra_addr;
    int            cnt;

    rst_n             = 1'b1;
    bus.i_fetch_ready = 1'b1;
    idle();
    #3 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_pc",    bus.o_fetch_pc, RST_PC);
    check("rst_valid", AW'(bus.o_fetch_valid), '0);
    check("rst_flush", AW'(bus.o_flush), '0);
    check("rst_count", AW'(bus.o_ras_count), '0);
    rst_n = 1'b1;
    next_cycle();

    expect_out("seq0", 0, 1, 0, 64'h1000); next_cycle();
    expect_out("seq1", 0, 1, 0, 64'h1004); next_cycle();
    expect_out("seq2", 0, 1, 0, 64'h1008); drive_jal(64'h1008, 64'h100, 1); next_cycle();
    expect_out("jal", 1, 1, 1, 64'h1108); idle(); next_cycle();
    expect_out("jal_seq", 0, 1, 1, 64'h110C); drive_jalr(64'h1108, 0, 0, 1, 0); next_cycle();
    expect_out("ret", 1, 1, 0, 64'h100C); drive_jal(64'h100C, 64'h500, 1); next_cycle();
    expect_out("flush_ignores_dec", 0, 1, 0, 64'h1010); drive_branch(64'h2000, NEG8); next_cycle();
    expect_out("br_back", 1, 1, 0, 64'h1FF8); idle(); next_cycle();
    expect_out("br_back_seq", 0, 1, 0, 64'h1FFC); drive_branch(64'h2000, 64'h10); next_cycle();
    expect_out("br_fwd", 0, 1, 0, 64'h2000); idle(); bus.i_fetch_ready = 1'b0; next_cycle();
    expect_out("stall_hold", 0, 1, 0, 64'h2000); drive_branch(64'h2000, NEG8); next_cycle();
    expect_out("br_while_stalled", 1, 1, 0, 64'h1FF8); idle(); bus.i_fetch_ready = 1'b1; next_cycle();
    expect_out("stall_release", 0, 1, 0, 64'h1FFC); drive_jalr(64'h1FFC, 0, 0, 0, 0); next_cycle();
    expect_out("jalr_x5", 1, 0, 0, 64'h1FFC); idle(); next_cycle();
    check("wait_state", AW'(dbg_wait), 64'h1);
    check("wait_pc", bus.o_fetch_pc, 64'h1FFC);
    drive_jal(64'h1FFC, 64'h40, 1); next_cycle();
    check("wait_ignores_dec", AW'(bus.o_ras_count), '0);
    idle(); drive_redirect(64'h3000); next_cycle();
    expect_out("redirect", 1, 1, 0, 64'h3000); idle(); next_cycle();
    expect_out("redirect_seq", 0, 1, 0, 64'h3004); drive_jalr(64'h3004, 64'h4001, 1, 0, 1); next_cycle();
    expect_out("jalr_zero", 1, 1, 1, 64'h4000); idle(); next_cycle();
    expect_out("jalr_zero_seq", 0, 1, 1, 64'h4004);
    drive_jal(64'h4004, 64'h80, 1); drive_redirect(64'h5000); next_cycle();
    expect_out("redirect_beats_push", 1, 1, 1, 64'h5000); idle(); next_cycle();
    expect_out("rbp_seq", 0, 1, 1, 64'h5004); drive_jalr(64'h5004, 64'h4, 0, 1, 0); next_cycle();
    expect_out("ret_imm", 1, 1, 0, 64'h300C); idle(); next_cycle();
    expect_out("ret_imm_seq", 0, 1, 0, 64'h3010); drive_jal(64'h3010, 64'h10, 1); next_cycle();
    expect_out("jal_link2", 1, 1, 1, 64'h3020); idle(); drive_redirect(64'h6000); next_cycle();
    expect_out("flush_back_to_back", 1, 1, 1, 64'h6000); drive_jalr(64'h6000, 0, 0, 1, 1); next_cycle();
    expect_out("b2b_seq", 0, 1, 1, 64'h6004); drive_jalr(64'h6004, 0, 0, 1, 1); next_cycle();
    expect_out("ret_replace", 1, 1, 1, 64'h3014); idle(); next_cycle();
    expect_out("ret_replace_seq", 0, 1, 1, 64'h3018); drive_jalr(64'h3018, 0, 0, 1, 0); next_cycle();
    expect_out("ret_replaced_top", 1, 1, 0, 64'h6008); idle(); next_cycle();
    expect_out("rrt_seq", 0, 1, 0, 64'h600C);

    // RAS overflow: links A1..A9 with A_k = 0x7000 + 0x100*k + 4
    for (int k = 1; k <= 9; k++) begin
      dp  = 64'h7000 + AW'(k) * 64'h100;
      cnt = (k > RD) ? RD : k;
      drive_jal(dp, 64'h40, 1); next_cycle();
      expect_out("ovf_jal", 1, 1, cnt, dp + 64'h40); idle(); next_cycle();
      expect_out("ovf_jal_seq", 0, 1, cnt, dp + 64'h44);
    end
    for (int j = 1; j <= 8; j++) begin
      ra_addr = 64'h7000 + AW'(10 - j) * 64'h100 + 64'h4;
      drive_jalr(64'h8000, 0, 0, 1, 0); next_cycle();
      expect_out("ovf_ret", 1, 1, 8 - j, ra_addr); idle(); next_cycle();
      expect_out("ovf_ret_seq", 0, 1, 8 - j, ra_addr + 64'h4);
    end
    drive_jalr(64'h8000, 0, 0, 1, 0); next_cycle();
    expect_out("ras_empty_wait", 1, 0, 0, 64'h7208); idle(); next_cycle();
    drive_redirect(64'h9000); next_cycle();
    expect_out("redirect2", 1, 1, 0, 64'h9000); idle(); next_cycle();
    expect_out("redirect2_seq", 0, 1, 0, 64'h9004); drive_jal(64'h9004, 64'h20, 1); next_cycle();
    expect_out("pre_reset_jal", 1, 1, 1, 64'h9024); idle(); next_cycle();
    expect_out("pre_reset_seq", 0, 1, 1, 64'h9028);

    // reset mid-operation: state and RAS are discarded at once
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_pc",    bus.o_fetch_pc, RST_PC);
    check("mid_rst_valid", AW'(bus.o_fetch_valid), '0);
    check("mid_rst_flush", AW'(bus.o_flush), '0);
    check("mid_rst_count", AW'(bus.o_ras_count), '0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    next_cycle();
    expect_out("post_reset", 0, 1, 0, 64'h1000); drive_jalr(64'h1000, 0, 0, 1, 0); next_cycle();
    expect_out("post_reset_ras_empty", 1, 0, 0, 64'h1000); idle();
    @(negedge clk);
    #1;
    check("queue_drained", AW'(exp_q.size()), '0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
